// File: rtl/conv2d_pkg.sv
// rtl/conv2d_pkg.sv - shared constants, helpers and FSM encoding for the window generator
package conv2d_pkg;

  // Default geometry (28x28 image, 3x3 window, stride 1)
  localparam int BITWIDTH_DEF            = 8;
  localparam int IMAGE_WIDTH_DEF         = 28;
  localparam int IMAGE_HEIGHT_DEF        = 28;
  localparam int WEIGHT_WIDTH_DEF        = 3;
  localparam int WEIGHT_HEIGHT_DEF       = 3;
  localparam int STRIDE_DEF              = 1;

  localparam int OUT_IMAGE_WIDTH         = (IMAGE_WIDTH_DEF - WEIGHT_WIDTH_DEF) / STRIDE_DEF + 1;
  localparam int OUT_IMAGE_HEIGHT        = (IMAGE_HEIGHT_DEF - WEIGHT_HEIGHT_DEF) / STRIDE_DEF + 1;
  localparam int FEATURE_MAP_NUM         = OUT_IMAGE_WIDTH * OUT_IMAGE_HEIGHT;
  localparam int SINGLE_FEATURE_MAP_SIZE = WEIGHT_WIDTH_DEF * WEIGHT_HEIGHT_DEF;
  localparam int COL_W                   = $clog2(IMAGE_WIDTH_DEF);
  localparam int ROW_W                   = $clog2(IMAGE_HEIGHT_DEF);
  localparam int INDEX_W                 = $clog2(FEATURE_MAP_NUM);

  typedef enum logic [0:0] {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  // Output dimension along one axis for an unpadded strided window
  function automatic int out_dim(input int img, input int win, input int stride);
    return (img - win) / stride + 1;
  endfunction

  // Counter width that stays at least one bit for degenerate sizes
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// rtl/conv2d_line_buffer.sv - one-row delay line for the window generator
module conv2d_line_buffer
  import conv2d_pkg::*;
#(
  parameter int DEPTH = IMAGE_WIDTH_DEF,
  parameter int WIDTH = BITWIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Shift register: output is the sample accepted DEPTH shifts ago; contents are never read before being filled
  always_ff @(posedge clk_i) begin
    if (shift_en_i) begin
      mem_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign data_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_window_gen.sv
// rtl/conv2d_window_gen.sv - streaming sliding-window generator feeding the conv2d core
module conv2d_window_gen
  import conv2d_pkg::*;
#(
  parameter int BITWIDTH      = 8,
  parameter int IMAGE_WIDTH   = 28,
  parameter int IMAGE_HEIGHT  = 28,
  parameter int WEIGHT_WIDTH  = 3,
  parameter int WEIGHT_HEIGHT = 3,
  parameter int STRIDE        = 1,
  localparam int SZ  = WEIGHT_WIDTH * WEIGHT_HEIGHT,
  localparam int FMN = out_dim(IMAGE_WIDTH, WEIGHT_WIDTH, STRIDE) * out_dim(IMAGE_HEIGHT, WEIGHT_HEIGHT, STRIDE),
  localparam int IXW = cnt_w(FMN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITWIDTH-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SZ*BITWIDTH-1:0] feature_map,
  output logic [IXW-1:0]         out_index,
  output logic                   out_last
);

  localparam int CW = cnt_w(IMAGE_WIDTH);
  localparam int RW = cnt_w(IMAGE_HEIGHT);

  state_e                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [IXW-1:0]         idx_q, idx_d;
  logic                   out_valid_q, out_valid_d;
  logic [SZ*BITWIDTH-1:0] fm_q, fm_d;
  logic [IXW-1:0]         oidx_q, oidx_d;
  logic                   last_q, last_d;
  logic [BITWIDTH-1:0]    win_q [WEIGHT_HEIGHT][WEIGHT_WIDTH];
  logic [BITWIDTH-1:0]    win_d [WEIGHT_HEIGHT][WEIGHT_WIDTH];
  logic [BITWIDTH-1:0]    tap   [WEIGHT_HEIGHT];
  logic [BITWIDTH-1:0]    lb_in [WEIGHT_HEIGHT-1];
  logic [BITWIDTH-1:0]    lb_out[WEIGHT_HEIGHT-1];
  logic [SZ*BITWIDTH-1:0] fm_next;
  logic                   accept, emit, col_end, row_end;
  logic [CW-1:0]          col_off;
  logic [RW-1:0]          row_off;

  // A pending window blocks new input, so it can never be overwritten
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col_q == CW'(IMAGE_WIDTH - 1));
  assign row_end  = (row_q == RW'(IMAGE_HEIGHT - 1));

  // Bottom window row is the live pixel; each cascaded line buffer supplies the row above
  assign tap[WEIGHT_HEIGHT-1] = in_data;
  for (genvar k = 0; k < WEIGHT_HEIGHT - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_in[k] = in_data;
    end else begin : g_next
      assign lb_in[k] = lb_out[k-1];
    end
    assign tap[WEIGHT_HEIGHT-2-k] = lb_out[k];
    conv2d_line_buffer #(
      .DEPTH (IMAGE_WIDTH),
      .WIDTH (BITWIDTH)
    ) u_lb (
      .clk_i      (clk),
      .shift_en_i (accept),
      .data_i     (lb_in[k]),
      .data_o     (lb_out[k])
    );
  end

  // Raster position of the pixel being accepted; wraps into the next frame with no gap
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Fill/stream state: stream once the first WEIGHT_HEIGHT-1 rows are buffered
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:   if (accept && col_end && (row_q == RW'(WEIGHT_HEIGHT - 2))) state_d = S_STREAM;
      S_STREAM: if (accept && col_end && row_end) state_d = S_FILL;
      default:  state_d = S_FILL;
    endcase
  end

  // Window shifts left one column per accepted pixel, new column from the taps
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < WEIGHT_HEIGHT; r++) begin
        for (int c = 0; c < WEIGHT_WIDTH - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WEIGHT_WIDTH-1] = tap[r];
      end
    end
  end

  // Pack top-left element into the MSBs, row-major
  always_comb begin
    fm_next = '0;
    for (int r = 0; r < WEIGHT_HEIGHT; r++) begin
      for (int c = 0; c < WEIGHT_WIDTH; c++) begin
        fm_next[(SZ-1-(r*WEIGHT_WIDTH+c))*BITWIDTH +: BITWIDTH] = win_d[r][c];
      end
    end
  end

  // Stream state already guarantees row >= WEIGHT_HEIGHT-1; column and stride phase checked here
  assign col_off = col_q - CW'(WEIGHT_WIDTH - 1);
  assign row_off = row_q - RW'(WEIGHT_HEIGHT - 1);
  assign emit    = (state_q == S_STREAM) && (col_q >= CW'(WEIGHT_WIDTH - 1)) &&
                   ((col_off % CW'(STRIDE)) == '0) && ((row_off % RW'(STRIDE)) == '0);

  // Output register: reload on a completing pixel, otherwise drop valid once consumed
  always_comb begin
    out_valid_d = out_valid_q;
    fm_d        = fm_q;
    oidx_d      = oidx_q;
    last_d      = last_q;
    idx_d       = idx_q;
    if (accept && emit) begin
      out_valid_d = 1'b1;
      fm_d        = fm_next;
      oidx_d      = idx_q;
      last_d      = (idx_q == IXW'(FMN - 1));
      idx_d       = (idx_q == IXW'(FMN - 1)) ? '0 : idx_q + IXW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      col_q       <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      fm_q        <= '0;
      oidx_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      fm_q        <= fm_d;
      oidx_q      <= oidx_d;
      last_q      <= last_d;
    end
  end

  // Window storage is data only; it is always overwritten before it is emitted
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign out_valid   = out_valid_q;
  assign feature_map = fm_q;
  assign out_index   = oidx_q;
  assign out_last    = last_q;

endmodule

// File: tb/tb_conv2d_window_gen.sv
// tb/tb_conv2d_window_gen.sv - self-checking bench for conv2d_window_gen
module tb_conv2d_window_gen;

  typedef struct {
    logic [71:0] fm;
    int          idx;
    logic        last;
  } win_t;

  typedef struct {
    int          scen;
    int          pos;
    logic [71:0] fm;
    int          idx;
    logic        last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         sel;
  logic       iv_m;
  logic [7:0] idat;
  logic       man_ready, rand_ready, rnd_bit, gap_en;
  logic       ordy;
  int         checks, failures;
  win_t       rcv[$];
  win_t       expq[$];
  vec_t       vecs[12];

  assign ordy = rand_ready ? rnd_bit : man_ready;

  logic iv0, iv1, iv2, or0, or1, or2;
  logic ir0, ir1, ir2, ov0, ov1, ov2, ol0, ol1, ol2;
  logic [71:0] fm0, fm1, fm2;
  logic [1:0]  ix0, ix1;
  logic [9:0]  ix2;

  assign iv0 = (sel == 0) && iv_m;
  assign iv1 = (sel == 1) && iv_m;
  assign iv2 = (sel == 2) && iv_m;
  assign or0 = (sel == 0) ? ordy : 1'b1;
  assign or1 = (sel == 1) ? ordy : 1'b1;
  assign or2 = (sel == 2) ? ordy : 1'b1;

  conv2d_window_gen #(.BITWIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3), .STRIDE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(idat),
    .out_valid(ov0), .out_ready(or0), .feature_map(fm0), .out_index(ix0), .out_last(ol0));
  conv2d_window_gen #(.BITWIDTH(8), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3), .STRIDE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(idat),
    .out_valid(ov1), .out_ready(or1), .feature_map(fm1), .out_index(ix1), .out_last(ol1));
  conv2d_window_gen #(.BITWIDTH(8), .IMAGE_WIDTH(28), .IMAGE_HEIGHT(28), .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3), .STRIDE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(idat),
    .out_valid(ov2), .out_ready(or2), .feature_map(fm2), .out_index(ix2), .out_last(ol2));

  logic        ir_m, ov_m, ol_m;
  logic [71:0] fm_m;
  logic [9:0]  ix_m;
  assign ir_m = (sel == 0) ? ir0 : (sel == 1) ? ir1 : ir2;
  assign ov_m = (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
  assign ol_m = (sel == 0) ? ol0 : (sel == 1) ? ol1 : ol2;
  assign fm_m = (sel == 0) ? fm0 : (sel == 1) ? fm1 : fm2;
  assign ix_m = (sel == 0) ? {8'd0, ix0} : (sel == 1) ? {8'd0, ix1} : ix2;

  // Random downstream readiness, about 30% stall cycles
  initial rnd_bit = 1'b1;
  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(99) >= 30);
  end

  // Collect every completed output handshake
  always @(negedge clk) begin
    win_t w;
    if (rst_n && ov_m && ordy) begin
      w.fm   = fm_m;
      w.idx  = int'(ix_m);
      w.last = ol_m;
      rcv.push_back(w);
    end
  end

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic send_pixel(input logic [7:0] d);
    int  n;
    logic ok;
    n = 0;
    while (gap_en && ($urandom_range(99) < 30)) begin
      iv_m = 1'b0;
      @(posedge clk); #1;
    end
    iv_m = 1'b1;
    idat = d;
    do begin
      @(negedge clk);
      ok = ir_m;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 1000);
    iv_m = 1'b0;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout got=in_ready_low exp=accept_within_1000");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "input handshake never completed");
    end
  endtask

  task automatic send_frame(input logic [7:0] px[$]);
    foreach (px[i]) send_pixel(px[i]);
  endtask

  // Reference: enumerate output positions in raster order and read each window from the image
  task automatic model_frame(input int iw, input int ih, input int s, input logic [7:0] px[$]);
    int   ow, oh, n;
    win_t w;
    ow = (iw - 3) / s + 1;
    oh = (ih - 3) / s + 1;
    n  = 0;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        w.fm = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w.fm = {w.fm[63:0], px[(oy*s + r)*iw + ox*s + c]};
        w.idx  = n;
        w.last = (n == ow*oh - 1);
        n++;
        expq.push_back(w);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ov_m && n < 2000);
    if (ov_m) begin
      failures++;
      $display("FAIL drain_timeout got=out_valid_high exp=drained");
    end
    @(posedge clk); #1;
  endtask

  task automatic compare_all(input string nm);
    checks++;
    if (rcv.size() != expq.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", nm, rcv.size(), expq.size());
    end
    for (int i = 0; i < rcv.size() && i < expq.size(); i++) begin
      checks++;
      if (rcv[i].fm !== expq[i].fm || rcv[i].idx != expq[i].idx || rcv[i].last !== expq[i].last) begin
        failures++;
        $display("FAIL %s_win%0d got=%h/%0d/%b exp=%h/%0d/%b", nm, i,
                 rcv[i].fm, rcv[i].idx, rcv[i].last, expq[i].fm, expq[i].idx, expq[i].last);
      end
    end
  endtask

  task automatic apply_table(input int scen);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].scen == scen) begin
        checks++;
        if (vecs[i].pos >= rcv.size()) begin
          failures++;
          $display("FAIL vec%0d_missing got=%0d_windows exp=pos%0d", i, rcv.size(), vecs[i].pos);
        end else if (rcv[vecs[i].pos].fm !== vecs[i].fm || rcv[vecs[i].pos].idx != vecs[i].idx ||
                     rcv[vecs[i].pos].last !== vecs[i].last) begin
          failures++;
          $display("FAIL vec%0d got=%h/%0d/%b exp=%h/%0d/%b", i, rcv[vecs[i].pos].fm,
                   rcv[vecs[i].pos].idx, rcv[vecs[i].pos].last, vecs[i].fm, vecs[i].idx, vecs[i].last);
        end
      end
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_out_valid"}, {71'd0, ov_m}, 72'd0);
    chk({nm, "_feature_map"}, fm_m, 72'd0);
    chk({nm, "_out_index"}, {62'd0, ix_m}, 72'd0);
    chk({nm, "_out_last"}, {71'd0, ol_m}, 72'd0);
    chk({nm, "_in_ready"}, {71'd0, ir_m}, 72'd1);
  endtask

  initial begin
    logic [7:0]  px[$];
    logic [7:0]  f2[$];
    logic [71:0] snap_fm;
    logic [9:0]  snap_ix;

    vecs[0]  = '{1, 0, 72'h010203_050607_090A0B, 0, 1'b0};
    vecs[1]  = '{1, 1, 72'h020304_060708_0A0B0C, 1, 1'b0};
    vecs[2]  = '{1, 2, 72'h050607_090A0B_0D0E0F, 2, 1'b0};
    vecs[3]  = '{1, 3, 72'h060708_0A0B0C_0E0F10, 3, 1'b1};
    vecs[4]  = '{2, 0, 72'h010203_060708_0B0C0D, 0, 1'b0};
    vecs[5]  = '{2, 1, 72'h030405_08090A_0D0E0F, 1, 1'b0};
    vecs[6]  = '{2, 2, 72'h0B0C0D_101112_151617, 2, 1'b0};
    vecs[7]  = '{2, 3, 72'h0D0E0F_121314_171819, 3, 1'b1};
    vecs[8]  = '{4, 3, 72'h060708_0A0B0C_0E0F10, 3, 1'b1};
    vecs[9]  = '{4, 4, 72'h111213_151617_191A1B, 0, 1'b0};
    vecs[10] = '{4, 7, 72'h161718_1A1B1C_1E1F20, 3, 1'b1};
    vecs[11] = '{4, 0, 72'h010203_050607_090A0B, 0, 1'b0};

    checks = 0; failures = 0;
    sel = 0; iv_m = 1'b0; idat = 8'd0;
    man_ready = 1'b1; rand_ready = 1'b0; gap_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 4x4, stride 1
    px.delete();
    for (int i = 1; i <= 16; i++) px.push_back(8'(i));
    model_frame(4, 4, 1, px);
    send_frame(px);
    drain();
    compare_all("s1");
    apply_table(1);
    rcv.delete(); expq.delete();

    // 5x5, stride 2
    sel = 1;
    px.delete();
    for (int i = 1; i <= 25; i++) px.push_back(8'(i));
    model_frame(5, 5, 2, px);
    send_frame(px);
    drain();
    compare_all("s2");
    apply_table(2);
    rcv.delete(); expq.delete();

    // Backpressure on the first window of a 4x4 frame
    sel = 0;
    px.delete();
    for (int i = 1; i <= 16; i++) px.push_back(8'(i));
    model_frame(4, 4, 1, px);
    man_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_pixel(px[i]);
    @(negedge clk);
    snap_fm = fm_m;
    snap_ix = ix_m;
    chk("bp_pending_valid", {71'd0, ov_m}, 72'd1);
    chk("bp_pending_fm", snap_fm, 72'h010203_050607_090A0B);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {71'd0, ov_m}, 72'd1);
      chk("bp_hold_fm", fm_m, snap_fm);
      chk("bp_hold_index", {62'd0, ix_m}, {62'd0, snap_ix});
      chk("bp_hold_in_ready", {71'd0, ir_m}, 72'd0);
    end
    @(posedge clk); #1;
    man_ready = 1'b1;
    for (int i = 11; i < 16; i++) send_pixel(px[i]);
    drain();
    compare_all("bp");
    rcv.delete(); expq.delete();

    // Two back-to-back 4x4 frames
    f2.delete();
    for (int i = 17; i <= 32; i++) f2.push_back(8'(i));
    model_frame(4, 4, 1, px);
    model_frame(4, 4, 1, f2);
    send_frame(px);
    send_frame(f2);
    drain();
    compare_all("b2b");
    apply_table(4);
    rcv.delete(); expq.delete();

    // Reset after 9 pixels, then a clean frame
    for (int i = 0; i < 9; i++) send_pixel(px[i]);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    rcv.delete();
    model_frame(4, 4, 1, px);
    send_frame(px);
    drain();
    compare_all("rst");
    apply_table(1);
    rcv.delete(); expq.delete();

    // Random 28x28 frame with input gaps and output stalls
    sel = 2;
    gap_en = 1'b1;
    rand_ready = 1'b1;
    px.delete();
    for (int i = 0; i < 784; i++) px.push_back(8'($urandom_range(255)));
    model_frame(28, 28, 1, px);
    send_frame(px);
    drain();
    compare_all("rand");
    rcv.delete(); expq.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2d_window_gen.md
# conv2d_window_gen

Streaming sliding-window generator that sits directly upstream of the conv2d compute core. It accepts one image pixel per handshake in raster order, buffers `WEIGHT_HEIGHT-1` image rows, and emits each `WEIGHT_HEIGHT x WEIGHT_WIDTH` feature map (receptive field) as one packed word. Each emitted word carries its output-pixel index. The core consumes these words and needs no whole-image register.

## Interface
- `BITWIDTH`, 8, pixel width.
- `IMAGE_WIDTH`, 28, pixels per row.
- `IMAGE_HEIGHT`, 28, rows per frame.
- `WEIGHT_WIDTH`, 3, window width.
- `WEIGHT_HEIGHT`, 3, window height.
- `STRIDE`, 1, window step in both axes.
- No padding support; PADDING is fixed at 0.
- Derived values:
  - `OUT_IMAGE_WIDTH = (IMAGE_WIDTH-WEIGHT_WIDTH)/STRIDE+1`
  - `OUT_IMAGE_HEIGHT` likewise, using `IMAGE_HEIGHT` and `WEIGHT_HEIGHT`
  - `FEATURE_MAP_NUM = OUT_IMAGE_WIDTH*OUT_IMAGE_HEIGHT`
  - `SINGLE_FEATURE_MAP_SIZE = WEIGHT_WIDTH*WEIGHT_HEIGHT`

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts a pixel this cycle.
- `in_data` in `BITWIDTH`: pixel, raster order.
- `out_valid` out 1: `feature_map` is valid.
- `out_ready` in 1: downstream accepts the word.
- `feature_map` out `SINGLE_FEATURE_MAP_SIZE*BITWIDTH`: packed window.
- `out_index` out `$clog2(FEATURE_MAP_NUM)`: raster index of the output pixel.
- `out_last` out 1: last window of the frame.

## Operation
- **Handshakes.**
  - Input handshake: `in_valid && in_ready`.
  - Output handshake: `out_valid && out_ready`.
- **Position counters.**
  - `col` (0..IMAGE_WIDTH-1) and `row` (0..IMAGE_HEIGHT-1) advance only on an input handshake.
  - `col` wraps to 0 and then increments `row`.
  - After pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), both counters return to 0 and the next frame starts with no gap.
- **Line buffers.** `WEIGHT_HEIGHT-1` row-delay buffers of depth IMAGE_WIDTH, cascaded. They shift only on an input handshake.
- **Window register.** `WEIGHT_HEIGHT x WEIGHT_WIDTH` shift registers are fed from the incoming pixel and the buffer taps. Each row shifts left by one column per input handshake.
- **Emit condition.** The block emits when the accepted pixel at (row, col) satisfies all of:
  - `row >= WEIGHT_HEIGHT-1` and `col >= WEIGHT_WIDTH-1`
  - `(row-WEIGHT_HEIGHT+1) % STRIDE == 0`
  - `(col-WEIGHT_WIDTH+1) % STRIDE == 0`
- **Window contents.** The emitted window covers rows `row-WEIGHT_HEIGHT+1..row` and cols `col-WEIGHT_WIDTH+1..col`.
- **Packing.** Element (r,c) occupies `feature_map[(SINGLE_FEATURE_MAP_SIZE-1-(r*WEIGHT_WIDTH+c))*BITWIDTH +: BITWIDTH]`. This puts the top-left element in the MSBs, row-major.
- **out_index.** Counts emitted windows 0..FEATURE_MAP_NUM-1, then wraps to 0.
- **out_last.** Asserted with the window whose `out_index` is `FEATURE_MAP_NUM-1`.
- **FSM states.**
  - S_FILL: rows 0..WEIGHT_HEIGHT-2 are loading; no emission.
  - S_STREAM: emission is possible.
  - Transitions: S_FILL→S_STREAM on accepting the last pixel of row WEIGHT_HEIGHT-2. S_STREAM→S_FILL on accepting the last pixel of the frame.
- **Backpressure.**
  - Single output register.
  - `in_ready = !out_valid || out_ready`, combinational.
  - A pending window is never overwritten or dropped.
- **Word width.** Pixel values pass through unmodified; no arithmetic is performed on data.

## Timing
- **Reset values.** `out_valid`, `feature_map`, `out_index` and `out_last` are 0. `in_ready` is 1 (it follows from `out_valid`=0). Counters are 0 and the state is S_FILL.
- **Reset scope.** Line-buffer and window contents are not reset; they are never exposed before being overwritten.
- **Latency.** 1 cycle: the completing pixel is accepted at edge N, and `out_valid`/`feature_map` are valid after edge N.
- **Stall stability.** While `out_valid && !out_ready`, `feature_map`, `out_index` and `out_last` hold stable and `in_ready` is 0.
- **Simultaneous events.** Output accept and new input in the same cycle are allowed. The register reloads if the new pixel completes a window; otherwise `out_valid` drops.
- **Throughput.** With STRIDE=1 and `out_ready` tied high, one window per input pixel once in S_STREAM.
- **Mid-operation reset.** Reset asserted mid-frame aborts immediately. The next accepted pixel is treated as (0,0) of a new frame, and `out_index` restarts at 0.

## Structure
- Shared package `conv2d_pkg`:
  - derived constants: `OUT_IMAGE_WIDTH`, `OUT_IMAGE_HEIGHT`, `FEATURE_MAP_NUM`, `SINGLE_FEATURE_MAP_SIZE`;
  - counter widths (`$clog2`);
  - FSM state encoding (S_FILL, S_STREAM).
- Sub-module `conv2d_line_buffer`:
  - one-row delay line, depth IMAGE_WIDTH, width BITWIDTH;
  - shift-enable input;
  - instantiated WEIGHT_HEIGHT-1 times.

## Test plan
- **4x4 image, pixels 0x01..0x10, 3x3, STRIDE=1, `out_ready`=1.** Expect exactly 4 windows:
  - index 0: `72'h010203_050607_090A0B`
  - index 3: `72'h060708_0A0B0C_0E0F10`, with `out_last`=1 only on index 3.
- **5x5 image, pixels 0x01..0x19, STRIDE=2.** Expect 4 windows:
  - `010203_060708_0B0C0D`
  - `030405_08090A_0D0E0F`
  - `0B0C0D_101112_151617`
  - `0D0E0F_121314_171819`
- **Backpressure.** Hold `out_ready`=0 for 5 cycles while a window is pending. `feature_map` and `out_index` stay unchanged and `in_ready`=0 throughout. Release: each window is delivered exactly once, with no loss or duplication.
- **Two back-to-back 4x4 frames.** Send 1..16 then 17..32 with no gap. Second frame's index-0 window is `72'h111213_151617_191A1B`, and `out_index` restarts at 0.
- **Reset mid-frame.** Assert `rst_n`=0 after 9 pixels, then send a full 4x4 frame. Outputs read 0 during reset, and the output sequence is identical to scenario 1.
- **Random `in_valid`/`out_ready` gaps (30%), 28x28 frame.** Output is 676 windows matching a reference model, in index order.
